// File: rtl/mux_nx1_arb.sv
`default_nettype none
// ======================================================================
// mux_nx1_arb : N-to-1 registered mux with valid/ready, select or round-robin
// Rev 1.0
// ======================================================================
module mux_nx1_arb #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 2,
   parameter int MODE   = 0,
   parameter int SEL_W  = $clog2(NUM_IN),
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        out_src,
   output logic [CNT_W-1:0]        xfer_cnt
);

   logic             load_en;
   logic             xfer;
   logic             grant_vld;
   logic [SEL_W-1:0] grant;
   logic [WIDTH-1:0] grant_data;

   assign load_en = !out_valid || out_ready;

   generate
      if (MODE == 0) begin : g_sel
         // Out-of-range select values match no channel, so they never grant.
         always_comb begin
            grant     = '0;
            grant_vld = 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
               if (sel == SEL_W'(i) && in_valid[i]) begin
                  grant     = SEL_W'(i);
                  grant_vld = 1'b1;
               end
            end
         end
      end else begin : g_rr
         logic [SEL_W-1:0] rr_ptr;

         // Two ascending passes: channels at/after the pointer first, then the wrapped ones.
         always_comb begin
            grant     = '0;
            grant_vld = 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
               if (!grant_vld && in_valid[i] && rr_ptr <= SEL_W'(i)) begin
                  grant     = SEL_W'(i);
                  grant_vld = 1'b1;
               end
            end
            for (int i = 0; i < NUM_IN; i++) begin
               if (!grant_vld && in_valid[i] && SEL_W'(i) < rr_ptr) begin
                  grant     = SEL_W'(i);
                  grant_vld = 1'b1;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rr_ptr <= '0;
            end else if (xfer) begin
               rr_ptr <= (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + SEL_W'(1);
            end
         end
      end
   endgenerate

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant == SEL_W'(i)) begin
            grant_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Gated by rst_n so no channel sees an accept while the block is held in reset.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         in_ready[i] = rst_n && load_en && grant_vld && (grant == SEL_W'(i));
      end
   end

   assign xfer = |in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         xfer_cnt  <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= grant_data;
         out_src   <= grant;
         xfer_cnt  <= xfer_cnt + CNT_W'(1);
      end else if (load_en) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_arb.sv
`default_nettype none
// ======================================================================
// tb_mux_nx1_arb : scoreboard bench over three configurations of mux_nx1_arb
// Rev 1.0
// ======================================================================
module tb_mux_nx1_arb;

   typedef logic [33:0] beat_t;   // {src[1:0], data[31:0]}

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] din [3];
   logic [3:0]   vin [3];
   logic [1:0]   seli [3];
   logic [2:0]   ordy;

   wire [1:0]  ir0;  wire [31:0] od0;  wire ov0;  wire [0:0] os0;  wire [15:0] oc0;
   wire [3:0]  ir1;  wire [31:0] od1;  wire ov1;  wire [1:0] os1;  wire [15:0] oc1;
   wire [2:0]  ir2;  wire [31:0] od2;  wire ov2;  wire [1:0] os2;  wire [15:0] oc2;

   int    n_cmp = 0;
   int    n_err = 0;
   beat_t sb0[$], sb1[$], sb2[$];
   int    mrr  [3];
   int    mcnt [3];
   logic [3:0] acc [3];

   always #5 clk = ~clk;

   mux_nx1_arb #(.WIDTH(32), .NUM_IN(2), .MODE(0), .CNT_W(16)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_data(din[0][63:0]), .in_valid(vin[0][1:0]),
      .in_ready(ir0), .sel(seli[0][0:0]), .out_data(od0), .out_valid(ov0),
      .out_ready(ordy[0]), .out_src(os0), .xfer_cnt(oc0));

   mux_nx1_arb #(.WIDTH(32), .NUM_IN(4), .MODE(1), .CNT_W(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_data(din[1]), .in_valid(vin[1]),
      .in_ready(ir1), .sel(seli[1]), .out_data(od1), .out_valid(ov1),
      .out_ready(ordy[1]), .out_src(os1), .xfer_cnt(oc1));

   mux_nx1_arb #(.WIDTH(32), .NUM_IN(3), .MODE(0), .CNT_W(16)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_data(din[2][95:0]), .in_valid(vin[2][2:0]),
      .in_ready(ir2), .sel(seli[2]), .out_data(od2), .out_valid(ov2),
      .out_ready(ordy[2]), .out_src(os2), .xfer_cnt(oc2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int n_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 4 : 3);
   endfunction

   function automatic int sb_size(input int k);
      case (k)
         0:       return sb0.size();
         1:       return sb1.size();
         default: return sb2.size();
      endcase
   endfunction

   function automatic beat_t sb_front(input int k);
      case (k)
         0:       return sb0[0];
         1:       return sb1[0];
         default: return sb2[0];
      endcase
   endfunction

   task automatic sb_pop(input int k);
      case (k)
         0:       void'(sb0.pop_front());
         1:       void'(sb1.pop_front());
         default: void'(sb2.pop_front());
      endcase
   endtask

   task automatic sb_push(input int k, input beat_t b);
      case (k)
         0:       sb0.push_back(b);
         1:       sb1.push_back(b);
         default: sb2.push_back(b);
      endcase
   endtask

   // One cycle of reference model + comparisons for configuration k.
   task automatic proc(input int k);
      logic        ov;
      logic [31:0] od;
      logic [1:0]  os;
      logic [15:0] oc;
      logic [3:0]  ir;
      logic [3:0]  exp_ir;
      beat_t       front;
      int          n, sz, g, s, idx;
      bit          gv, le;
      case (k)
         0:       begin ov = ov0; od = od0; os = {1'b0, os0}; oc = oc0; ir = {2'b00, ir0}; end
         1:       begin ov = ov1; od = od1; os = os1;         oc = oc1; ir = ir1;          end
         default: begin ov = ov2; od = od2; os = os2;         oc = oc2; ir = {1'b0, ir2};  end
      endcase
      n  = n_of(k);
      sz = sb_size(k);
      g  = 0;
      gv = 1'b0;
      chk($sformatf("d%0d_valid", k), 64'(ov), 64'(sz > 0));
      chk($sformatf("d%0d_cnt", k), 64'(oc), 64'(mcnt[k] & 16'hFFFF));
      if (sz > 0) begin
         front = sb_front(k);
         chk($sformatf("d%0d_data", k), 64'(od), 64'(front[31:0]));
         chk($sformatf("d%0d_src", k), 64'(os), 64'(front[33:32]));
         if (ordy[k]) sb_pop(k);
      end
      if (k == 1) begin
         for (int off = 0; off < n; off++) begin
            idx = (mrr[k] + off) % n;
            if (!gv && vin[k][2'(idx)]) begin
               g  = idx;
               gv = 1'b1;
            end
         end
      end else begin
         s = (k == 0) ? int'(seli[0][0]) : int'(seli[k]);
         if (s < n && vin[k][2'(s)]) begin
            g  = s;
            gv = 1'b1;
         end
      end
      le     = (sz == 0) || ordy[k];
      exp_ir = (le && gv) ? (4'b0001 << g) : 4'b0000;
      chk($sformatf("d%0d_ready", k), 64'(ir), 64'(exp_ir));
      acc[k] = exp_ir;
      if (le && gv) begin
         sb_push(k, {2'(g), din[k][g*32 +: 32]});
         mcnt[k]++;
         if (k == 1) mrr[k] = (g == n - 1) ? 0 : g + 1;
      end
   endtask

   task automatic tick();
      #1;
      for (int k = 0; k < 3; k++) proc(k);
      @(negedge clk);
   endtask

   task automatic idle_all();
      for (int k = 0; k < 3; k++) vin[k] = 4'b0000;
      ordy = 3'b111;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
   task automatic mid_reset();
      #3 rst_n = 1'b0;
      #1;
      chk("rst_valid0", 64'(ov0), 64'd0);  chk("rst_data0", 64'(od0), 64'd0);
      chk("rst_cnt0", 64'(oc0), 64'd0);    chk("rst_ready0", 64'(ir0), 64'd0);
      chk("rst_valid1", 64'(ov1), 64'd0);  chk("rst_data1", 64'(od1), 64'd0);
      chk("rst_cnt1", 64'(oc1), 64'd0);    chk("rst_ready1", 64'(ir1), 64'd0);
      chk("rst_valid2", 64'(ov2), 64'd0);  chk("rst_data2", 64'(od2), 64'd0);
      chk("rst_cnt2", 64'(oc2), 64'd0);    chk("rst_ready2", 64'(ir2), 64'd0);
      sb0.delete(); sb1.delete(); sb2.delete();
      for (int k = 0; k < 3; k++) begin
         mrr[k]  = 0;
         mcnt[k] = 0;
         acc[k]  = 4'b0000;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Random traffic; a valid channel not yet accepted keeps its data and valid.
   task automatic rand_drive();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < n_of(k); i++) begin
            if (!(vin[k][i] && !acc[k][i])) begin
               vin[k][i]          = 1'($urandom_range(0, 1));
               din[k][i*32 +: 32] = $urandom;
            end
         end
         ordy[k] = ($urandom_range(0, 3) != 0);
         seli[k] = 2'($urandom_range(0, (k == 0) ? 1 : 3));
      end
   endtask

   initial begin
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         din[k]  = {4{32'hA5A5_0000 + 32'(k)}};
         vin[k]  = 4'b1111;
         seli[k] = 2'd0;
         mrr[k]  = 0;
         mcnt[k] = 0;
         acc[k]  = 4'b0000;
      end
      ordy = 3'b111;

      // Reset with active inputs
      mid_reset();
      idle_all();

      // Select mode, two channels
      din[0] = {64'h0, 32'h87654321, 32'h12345678};
      vin[0] = 4'b0011;
      seli[0] = 2'd0; tick();
      seli[0] = 2'd1; tick();
      vin[0] = 4'b0000; tick();
      chk("t2_cnt", 64'(oc0), 64'd2);

      // Stall with changing input, then drain and load
      vin[0] = 4'b0001; seli[0] = 2'd0; tick();
      ordy[0] = 1'b0; din[0][31:0] = 32'hDEADBEEF;
      repeat (3) tick();
      ordy[0] = 1'b1; tick();
      chk("t3_data", 64'(od0), 64'hDEADBEEF);
      vin[0] = 4'b0000; tick(); tick();

      // Round-robin, all channels valid
      din[1] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      vin[1] = 4'b1111;
      repeat (5) tick();
      vin[1] = 4'b0000; tick();

      // Round-robin wrap from pointer 3 with channels 0 and 2
      vin[1] = 4'b0100; tick();
      vin[1] = 4'b0101;
      repeat (3) tick();
      vin[1] = 4'b0000; tick(); tick();
      chk("t5_valid_fall", 64'(ov1), 64'd0);

      // Out-of-range select, then reset during a stall
      din[2] = {32'h0, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
      vin[2] = 4'b0111; seli[2] = 2'd3;
      tick(); tick();
      chk("t6_nogrant", 64'(ov2), 64'd0);
      seli[2] = 2'd1; tick();
      ordy[2] = 1'b0; tick(); tick();
      mid_reset();
      idle_all();

      repeat (300) begin
         rand_drive();
         tick();
      end
      idle_all();
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
